// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt responder.
// Configuration macro: INT_LEVEL_EN (level-sensitive pending when defined).
package irq_pkg;

   localparam int N_IRQ_DEF = 5;
   localparam int ID_W_DEF  = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SVC  = 2'd2
   } state_t;

   // Returns {valid, id}; lowest set index wins.
   function automatic logic [ID_W_DEF:0] prio_enc(
      input logic [N_IRQ_DEF-1:0] vec
   );
      logic [ID_W_DEF:0] r;
      r = '0;
      for (int i = N_IRQ_DEF - 1; i >= 0; i--) begin
         if (vec[i]) r = {1'b1, ID_W_DEF'(i)};
      end
      return r;
   endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line synchronizer with rising-edge detector.
// Configuration macro: INT_LEVEL_EN (not used here).
module irq_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic sync_out,
   output logic rise_pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sync_out   = sync_q[SYNC_STAGES-1];
   assign rise_pulse = sync_out & ~prev_q;

endmodule

// File: rtl/irq_responder.sv
// Interrupt responder: pending/mask registers, priority pick, req/ack/EOI FSM.
// Configuration macro: INT_LEVEL_EN selects level-sensitive pending.
module irq_responder
   import irq_pkg::*;
#(
   parameter int N_IRQ       = N_IRQ_DEF,
   parameter int ID_W        = ID_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_IRQ-1:0] int_,
   input  logic             mask_we,
   input  logic [N_IRQ-1:0] mask_wdata,
   output logic [N_IRQ-1:0] mask_q,
   output logic [N_IRQ-1:0] pend_q,
   output logic             irq_req,
   output logic [ID_W-1:0]  irq_id,
   input  logic             irq_ack,
   input  logic             irq_eoi,
   output logic             in_service
);

   logic [N_IRQ-1:0]  sync_v;
   logic [N_IRQ-1:0]  rise_v;
   logic [ID_W_DEF:0] win;
   state_t            state_q, state_d;
   logic [ID_W-1:0]   id_d;
   logic              ack_ok;

   for (genvar i = 0; i < N_IRQ; i++) begin : g_line
      irq_sync_edge #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
         .clk        (clk),
         .rst        (rst),
         .async_in   (int_[i]),
         .sync_out   (sync_v[i]),
         .rise_pulse (rise_v[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q <= '1;
      end else if (mask_we) begin
         mask_q <= mask_wdata;
      end
   end

`ifdef INT_LEVEL_EN
   logic [N_IRQ-1:0] unused_rise;
   logic             unused_ack;
   assign unused_rise = rise_v;
   assign unused_ack  = ack_ok;
   assign pend_q      = sync_v;
`else
   logic [N_IRQ-1:0] unused_sync;
   logic [N_IRQ-1:0] clr_v;
   assign unused_sync = sync_v;
   assign clr_v = ack_ok ? (N_IRQ'(1) << irq_id) : '0;

   // Set is OR-ed in after the clear, so a same-cycle edge survives.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= '0;
      end else begin
         pend_q <= (pend_q & ~clr_v) | rise_v;
      end
   end
`endif

   assign win = prio_enc(N_IRQ_DEF'(pend_q & mask_q));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         irq_id  <= '0;
      end else begin
         state_q <= state_d;
         irq_id  <= id_d;
      end
   end

   always_comb begin
      state_d = state_q;
      id_d    = irq_id;
      ack_ok  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (win[ID_W_DEF]) begin
               id_d    = ID_W'(win[ID_W_DEF-1:0]);
               state_d = REQ;
            end
         end
         REQ: begin
            if (irq_ack) begin
               ack_ok  = 1'b1;
               state_d = SVC;
            end
         end
         SVC: begin
            if (irq_eoi) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign irq_req    = (state_q == REQ);
   assign in_service = (state_q == SVC);

endmodule

// File: tb/tb_irq_responder.sv
// Directed self-checking bench for irq_responder.
// Covers edge mode by default and level mode when INT_LEVEL_EN is defined.
module tb_irq_responder;

   logic       clk;
   logic       rst;
   logic [4:0] int_;
   logic       mask_we;
   logic [4:0] mask_wdata;
   logic [4:0] mask_q;
   logic [4:0] pend_q;
   logic       irq_req;
   logic [2:0] irq_id;
   logic       irq_ack;
   logic       irq_eoi;
   logic       in_service;

   int checks = 0;
   int errors = 0;

   irq_responder dut (
      .clk        (clk),
      .rst        (rst),
      .int_       (int_),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .mask_q     (mask_q),
      .pend_q     (pend_q),
      .irq_req    (irq_req),
      .irq_id     (irq_id),
      .irq_ack    (irq_ack),
      .irq_eoi    (irq_eoi),
      .in_service (in_service)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_ack();
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
   endtask

   task automatic pulse_eoi();
      irq_eoi = 1'b1;
      step();
      irq_eoi = 1'b0;
   endtask

   task automatic write_mask(input logic [4:0] m);
      mask_we    = 1'b1;
      mask_wdata = m;
      step();
      mask_we    = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      int_       = '0;
      mask_we    = 1'b0;
      mask_wdata = '0;
      irq_ack    = 1'b0;
      irq_eoi    = 1'b0;
      step(2);
      chk("rst_pend", pend_q, 5'b00000);
      chk("rst_mask", mask_q, 5'b11111);
      chk("rst_req", irq_req, 1'b0);
      chk("rst_id", irq_id, 3'd0);
      chk("rst_svc", in_service, 1'b0);
      rst = 1'b0;
      step();

`ifndef INT_LEVEL_EN
      // Line 0 held high: latency and single event.
      int_ = 5'b00001;
      step(2);
      chk("t1_pend_k1", pend_q, 5'b00000);
      step();
      chk("t1_pend_k2", pend_q, 5'b00001);
      chk("t1_req_k2", irq_req, 1'b0);
      step();
      chk("t1_req_k3", irq_req, 1'b1);
      chk("t1_id", irq_id, 3'd0);
      pulse_ack();
      chk("t1_pend_ack", pend_q, 5'b00000);
      chk("t1_req_ack", irq_req, 1'b0);
      chk("t1_svc", in_service, 1'b1);
      pulse_eoi();
      chk("t1_svc_eoi", in_service, 1'b0);
      step(3);
      chk("t1_no_rereq", irq_req, 1'b0);
      chk("t1_no_pend", pend_q, 5'b00000);
      int_ = 5'b00000;
      step(3);

      // Simultaneous edges on lines 2 and 4.
      int_ = 5'b10100;
      step(4);
      chk("t2_pend", pend_q, 5'b10100);
      chk("t2_req", irq_req, 1'b1);
      chk("t2_id", irq_id, 3'd2);
      pulse_ack();
      chk("t2_pend_ack", pend_q, 5'b10000);
      pulse_eoi();
      chk("t2_req_eoi", irq_req, 1'b0);
      step();
      chk("t2_req4", irq_req, 1'b1);
      chk("t2_id4", irq_id, 3'd4);
      // ack and eoi together count as ack only
      irq_ack = 1'b1;
      irq_eoi = 1'b1;
      step();
      irq_ack = 1'b0;
      irq_eoi = 1'b0;
      chk("t2_ack_eoi_svc", in_service, 1'b1);
      chk("t2_pend_clr", pend_q, 5'b00000);
      pulse_eoi();
      int_ = 5'b00000;
      step(3);

      // Masked pending line.
      write_mask(5'b11110);
      chk("t3_mask", mask_q, 5'b11110);
      int_ = 5'b00001;
      step(4);
      chk("t3_pend", pend_q, 5'b00001);
      chk("t3_req_masked", irq_req, 1'b0);
      write_mask(5'b11111);
      chk("t3_req_w1", irq_req, 1'b0);
      step();
      chk("t3_req_w2", irq_req, 1'b1);
      chk("t3_id", irq_id, 3'd0);
      pulse_ack();
      pulse_eoi();
      int_ = 5'b00000;
      step(3);

      // Committed request is not preempted.
      int_ = 5'b01000;
      step(4);
      chk("t4_id3", irq_id, 3'd3);
      int_ = 5'b01010;
      write_mask(5'b10111);
      step(3);
      chk("t4_pend", pend_q, 5'b01010);
      chk("t4_req_hold", irq_req, 1'b1);
      chk("t4_id_hold", irq_id, 3'd3);
      pulse_ack();
      chk("t4_pend_ack", pend_q, 5'b00010);
      pulse_eoi();
      step();
      chk("t4_req1", irq_req, 1'b1);
      chk("t4_id1", irq_id, 3'd1);
      pulse_ack();
      pulse_eoi();
      write_mask(5'b11111);
      int_ = 5'b00000;
      step(3);

      // Reset mid-handshake, ack in the reset cycle ignored.
      int_ = 5'b00100;
      step(4);
      chk("t5_req", irq_req, 1'b1);
      write_mask(5'b00100);
      rst     = 1'b1;
      irq_ack = 1'b1;
      int_    = 5'b00000;
      step();
      rst     = 1'b0;
      irq_ack = 1'b0;
      chk("t5_req_rst", irq_req, 1'b0);
      chk("t5_pend_rst", pend_q, 5'b00000);
      chk("t5_mask_rst", mask_q, 5'b11111);
      chk("t5_svc_rst", in_service, 1'b0);
      pulse_ack();
      chk("t5_ack_idle_svc", in_service, 1'b0);
      chk("t5_ack_idle_req", irq_req, 1'b0);
      pulse_eoi();
      chk("t5_eoi_idle_svc", in_service, 1'b0);
`else
      // Level mode: pend tracks synchronized level.
      int_ = 5'b00100;
      step(2);
      chk("l1_pend", pend_q, 5'b00100);
      step();
      chk("l1_req", irq_req, 1'b1);
      chk("l1_id", irq_id, 3'd2);
      pulse_ack();
      chk("l1_svc", in_service, 1'b1);
      chk("l1_pend_ack", pend_q, 5'b00100);
      pulse_eoi();
      chk("l1_req_eoi", irq_req, 1'b0);
      step();
      chk("l1_rereq", irq_req, 1'b1);
      chk("l1_reid", irq_id, 3'd2);
      pulse_ack();
      int_ = 5'b00000;
      step(3);
      chk("l2_pend_drop", pend_q, 5'b00000);
      pulse_eoi();
      chk("l2_svc_eoi", in_service, 1'b0);
      step(2);
      chk("l2_no_rereq", irq_req, 1'b0);
      chk("l2_mask", mask_q, 5'b11111);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
